sprite_animator: RTL and testbench
==================================

Name: sprite_animator

Overview:
- Upstream address/frame generator for the sprite ROM stage.
- Converts the VGA scan position (DrawX/DrawY) and the sprite's screen position into sprite-local coordinates and a linear ROM address.
- Selects which of the three animation banks to read, and mirrors horizontally when the sprite faces left.
- Sprite position, facing and motion state are latched once per video frame, so a sprite never tears mid-scan.

Parameters:
- SPRITE_W, 24, sprite width in pixels.
- SPRITE_H, 45, sprite height in pixels.
- NUM_FRAMES, 3, number of animation frames (ROM banks).
- TICKS_PER_FRAME, 6, video frames each animation frame is held while walking.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current scan column, 0..639.
- DrawY  in  10  current scan row, 0..479.
- frameStart  in  1  one-cycle pulse at start of vertical blank.
- PosX  in  10  requested sprite top-left column; sampled only on frameStart.
- PosY  in  10  requested sprite top-left row; sampled only on frameStart.
- moving  in  1  walk request; sampled only on frameStart.
- faceLeft  in  1  facing request; sampled only on frameStart.
- inSprite  out  1  current scan pixel lies inside the sprite box.
- LocalX  out  5  sprite-local column after mirroring, 0..SPRITE_W-1.
- LocalY  out  6  sprite-local row, 0..SPRITE_H-1.
- Address  out  11  LocalY*SPRITE_W + LocalX, 0..1079.
- frameSel  out  2  animation bank index, 0..NUM_FRAMES-1.

Behaviour:
- Reset: every output is 0. State = IDLE, tick counter = 0, shadow PosX/PosY = 0, shadow faceLeft = 0.
- Reset has priority over a frameStart in the same cycle.
- A reset asserted mid-walk returns the block to IDLE with frameSel = 0.
- Shadow registers:
  - On each frameStart, PosX, PosY, moving and faceLeft are captured.
  - All geometry uses the shadow values only, so changes to PosX/PosY between frameStarts have no visible effect.
- Geometry:
  - dx = DrawX - shadowPosX and dy = DrawY - shadowPosY, computed as 11-bit signed values.
  - inSprite = (0 <= dx < SPRITE_W) and (0 <= dy < SPRITE_H).
  - Negative dx or dy means outside; there is no wrap-around at screen edges.
  - A sprite partly beyond column 639 or row 479 is simply clipped.
  - LocalY = dy.
  - LocalX = dx when facing right; LocalX = SPRITE_W-1-dx when facing left.
  - Address = LocalY*SPRITE_W + LocalX. Width rule: 6-bit x 5-bit product into an 11-bit result, no truncation.
  - When inSprite = 0, LocalX, LocalY and Address are all forced to 0.
- Latency:
  - inSprite, LocalX, LocalY and Address are registered, valid exactly 1 Clk after the corresponding DrawX/DrawY.
  - frameSel is registered and changes only in the cycle after a frameStart.
- Animation FSM, evaluated only on frameStart using the newly sampled moving bit:
  - IDLE: frameSel = 0, tick = 0. If moving = 1, go to WALK; frameSel stays 0, tick = 0.
  - WALK with moving = 1: tick increments. When tick reaches TICKS_PER_FRAME-1, tick clears and frameSel advances.
  - frameSel wraps from NUM_FRAMES-1 back to 0.
  - WALK with moving = 0: go to IDLE, frameSel = 0, tick = 0 (an immediate stand pose, not a finished cycle).
- Facing changes take effect at the next frameStart and do not reset the animation.

Test Plan:
1. Reset, then frameStart with PosX = 100, PosY = 200, faceLeft = 0. Scan DrawX = 100, DrawY = 200 -> one cycle later inSprite = 1, LocalX = 0, LocalY = 0, Address = 0. DrawX = 123, DrawY = 244 -> Address = 1079. DrawX = 124 -> inSprite = 0, Address = 0.
2. Same position with faceLeft = 1, DrawX = 100, DrawY = 201 -> LocalX = 23, Address = 47. DrawX = 123 -> LocalX = 0, Address = 24.
3. Change PosX to 300 with no frameStart; DrawX = 100, DrawY = 200 still gives inSprite = 1. After the next frameStart, DrawX = 100 gives inSprite = 0 and DrawX = 300 gives inSprite = 1.
4. moving = 1 held, 20 frameStarts -> frameSel sequence: 0 for 6 frames, 1 for 6, 2 for 6, then 0 (wrap). Drop moving mid-frame 1 -> frameSel = 0 the cycle after that frameStart.
5. Clipping: PosX = 630, PosY = 470, DrawX = 639, DrawY = 479 -> inSprite = 1, LocalX = 9, LocalY = 9, Address = 225. PosX = 0 with DrawX = 0 -> LocalX = 0; DrawX - PosX negative -> inSprite = 0.
6. Reset asserted while walking at frameSel = 2, in the same cycle as a frameStart -> next cycle frameSel = 0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/sprite_animator.sv
// Sprite address/frame generator feeding the sprite ROM stage.
// Turns the scan position into sprite-local coordinates and a linear ROM
// address, picks the animation bank, and mirrors the sprite when it faces left.
// Position, facing and walk state only change on frameStart, so a sprite
// never tears partway through a scan.
//
// Animation FSM states:
//   state | meaning
//   IDLE  | standing pose, frameSel held at 0, tick counter cleared
//   WALK  | walking; tick counts video frames, frameSel advances every
//         | TICKS_PER_FRAME frames and wraps after NUM_FRAMES banks
module sprite_animator #(
    parameter int SPRITE_W        = 24,
    parameter int SPRITE_H        = 45,
    parameter int NUM_FRAMES      = 3,
    parameter int TICKS_PER_FRAME = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frameStart,
    input  logic [9:0]  PosX,
    input  logic [9:0]  PosY,
    input  logic        moving,
    input  logic        faceLeft,
    output logic        inSprite,
    output logic [4:0]  LocalX,
    output logic [5:0]  LocalY,
    output logic [10:0] Address,
    output logic [1:0]  frameSel
);

    localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [1:0]        SEL_LAST  = 2'(NUM_FRAMES - 1);
    localparam logic signed [10:0] W_S      = 11'(SPRITE_W);
    localparam logic signed [10:0] H_S      = 11'(SPRITE_H);
    localparam logic [4:0]        X_LAST    = 5'(SPRITE_W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } animState_t;

    animState_t        state;
    logic [TICK_W-1:0] tick;

    logic [9:0] shPosX;
    logic [9:0] shPosY;
    logic       shFaceLeft;

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               hit;
    logic [4:0]         lxNext;
    logic [5:0]         lyNext;
    logic [10:0]        addrNext;

    // Capture position and facing once per video frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shPosX     <= '0;
            shPosY     <= '0;
            shFaceLeft <= 1'b0;
        end else if (frameStart) begin
            shPosX     <= PosX;
            shPosY     <= PosY;
            shFaceLeft <= faceLeft;
        end
    end

    // Animation sequencing; advances only on frameStart using the fresh moving bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            tick     <= '0;
            frameSel <= '0;
        end else if (frameStart) begin
            case (state)
                IDLE: begin
                    tick     <= '0;
                    frameSel <= '0;
                    if (moving) begin
                        state <= WALK;
                    end
                end
                WALK: begin
                    if (!moving) begin
                        // Stopping snaps straight to the stand pose.
                        state    <= IDLE;
                        tick     <= '0;
                        frameSel <= '0;
                    end else if (tick == TICK_LAST) begin
                        tick     <= '0;
                        frameSel <= (frameSel == SEL_LAST) ? 2'd0 : frameSel + 2'd1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick     <= '0;
                    frameSel <= '0;
                end
            endcase
        end
    end

    // Sprite-local coordinates and ROM address for the current scan pixel.
    always_comb begin
        // Zero-extend before subtracting so a pixel left of / above the
        // sprite goes negative instead of wrapping into the box.
        dx       = $signed({1'b0, DrawX}) - $signed({1'b0, shPosX});
        dy       = $signed({1'b0, DrawY}) - $signed({1'b0, shPosY});
        hit      = (dx >= 11'sd0) && (dx < W_S) && (dy >= 11'sd0) && (dy < H_S);
        lxNext   = '0;
        lyNext   = '0;
        addrNext = '0;
        if (hit) begin
            lxNext   = shFaceLeft ? (X_LAST - dx[4:0]) : dx[4:0];
            lyNext   = dy[5:0];
            addrNext = 11'(lyNext) * 11'(SPRITE_W) + 11'(lxNext);
        end
    end

    // Register the geometry so it lines up one clock behind DrawX/DrawY.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            inSprite <= 1'b0;
            LocalX   <= '0;
            LocalY   <= '0;
            Address  <= '0;
        end else begin
            inSprite <= hit;
            LocalX   <= lxNext;
            LocalY   <= lyNext;
            Address  <= addrNext;
        end
    end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed scenarios plus randomized frames,
// compared against an arithmetic reference model of the sprite geometry
// and walk-cycle timing.
module tb_sprite_animator;

    localparam int SW  = 24;
    localparam int SH  = 45;
    localparam int NF  = 3;
    localparam int TPF = 6;

    logic        Clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frameStart;
    logic [9:0]  PosX;
    logic [9:0]  PosY;
    logic        moving;
    logic        faceLeft;
    logic        inSprite;
    logic [4:0]  LocalX;
    logic [5:0]  LocalY;
    logic [10:0] Address;
    logic [1:0]  frameSel;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state
    int mPosX;
    int mPosY;
    bit mFace;
    bit mWalking;
    int mCount;

    sprite_animator dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frameStart (frameStart),
        .PosX       (PosX),
        .PosY       (PosY),
        .moving     (moving),
        .faceLeft   (faceLeft),
        .inSprite   (inSprite),
        .LocalX     (LocalX),
        .LocalY     (LocalY),
        .Address    (Address),
        .frameSel   (frameSel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int modelSel();
        return mWalking ? (mCount / TPF) % NF : 0;
    endfunction

    // Reset pulse, optionally colliding with a frameStart; all outputs must be 0 after it.
    task automatic doReset(input bit withFs);
        Reset      = 1'b1;
        frameStart = withFs;
        moving     = 1'b1;
        @(posedge Clk); #1;
        Reset      = 1'b0;
        frameStart = 1'b0;
        mPosX = 0; mPosY = 0; mFace = 0; mWalking = 0; mCount = 0;
        checkVal("rst_inSprite", int'(inSprite), 0);
        checkVal("rst_LocalX",   int'(LocalX),   0);
        checkVal("rst_LocalY",   int'(LocalY),   0);
        checkVal("rst_Address",  int'(Address),  0);
        checkVal("rst_frameSel", int'(frameSel), 0);
    endtask

    // One frameStart pulse; the model applies the same capture and walk rules.
    task automatic doFrame(input int px, input int py, input bit mv, input bit fl);
        PosX       = 10'(px);
        PosY       = 10'(py);
        moving     = mv;
        faceLeft   = fl;
        frameStart = 1'b1;
        @(posedge Clk); #1;
        frameStart = 1'b0;
        mPosX = px; mPosY = py; mFace = fl;
        if (!mv) begin
            mWalking = 0;
            mCount   = 0;
        end else if (!mWalking) begin
            mWalking = 1;
            mCount   = 0;
        end else begin
            mCount++;
        end
        checkVal("frameSel", int'(frameSel), modelSel());
    endtask

    // Present a scan position and check the registered result one clock later.
    task automatic scan(input int x, input int y);
        int dx, dy, lx, ly;
        bit hit;
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk); #1;
        dx  = x - mPosX;
        dy  = y - mPosY;
        hit = (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
        lx  = hit ? (mFace ? (SW - 1 - dx) : dx) : 0;
        ly  = hit ? dy : 0;
        checkVal("inSprite", int'(inSprite), int'(hit));
        checkVal("LocalX",   int'(LocalX),   lx);
        checkVal("LocalY",   int'(LocalY),   ly);
        checkVal("Address",  int'(Address),  ly * SW + lx);
        checkVal("selHold",  int'(frameSel), modelSel());
    endtask

    initial begin
        int px, py, x, y;
        Reset = 1'b1; DrawX = '0; DrawY = '0; frameStart = 1'b0;
        PosX = '0; PosY = '0; moving = 1'b0; faceLeft = 1'b0;
        @(posedge Clk); #1;
        doReset(1'b0);

        // Directed: facing right at (100,200)
        doFrame(100, 200, 1'b0, 1'b0);
        scan(100, 200);
        checkVal("tp1_addr0", int'(Address), 0);
        scan(123, 244);
        checkVal("tp1_addrMax", int'(Address), 1079);
        scan(124, 244);
        checkVal("tp1_rightEdge", int'(inSprite), 0);

        // Directed: facing left mirrors columns
        doFrame(100, 200, 1'b0, 1'b1);
        scan(100, 201);
        checkVal("tp2_lx", int'(LocalX), 23);
        checkVal("tp2_addr", int'(Address), 47);
        scan(123, 201);
        checkVal("tp2_addr2", int'(Address), 24);

        // Position changes are ignored until the next frameStart
        PosX = 10'd300;
        scan(100, 200);
        checkVal("tp3_stale", int'(inSprite), 1);
        doFrame(300, 200, 1'b0, 1'b0);
        scan(100, 200);
        checkVal("tp3_old", int'(inSprite), 0);
        scan(300, 200);
        checkVal("tp3_new", int'(inSprite), 1);

        // Walk cycle: 6 frames per bank, wrap after bank 2
        for (int k = 0; k < 20; k++) begin
            doFrame(300, 200, 1'b1, 1'b0);
            checkVal("tp4_seq", int'(frameSel), (k < 6) ? 0 : (k < 12) ? 1 : (k < 18) ? 2 : 0);
        end
        doFrame(300, 200, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) doFrame(300, 200, 1'b1, 1'b0);
        checkVal("tp4_bank1", int'(frameSel), 1);
        doFrame(300, 200, 1'b0, 1'b0);
        checkVal("tp4_stop", int'(frameSel), 0);

        // Facing change mid-walk keeps the animation going
        for (int k = 0; k < 7; k++) doFrame(300, 200, 1'b1, 1'b0);
        doFrame(300, 200, 1'b1, 1'b1);
        checkVal("faceKeep", int'(frameSel), 1);

        // Clipping at the screen edges
        doFrame(630, 470, 1'b0, 1'b0);
        scan(639, 479);
        checkVal("tp5_lx", int'(LocalX), 9);
        checkVal("tp5_ly", int'(LocalY), 9);
        checkVal("tp5_addr", int'(Address), 225);
        doFrame(0, 0, 1'b0, 1'b0);
        scan(0, 0);
        checkVal("tp5_origin", int'(inSprite), 1);
        doFrame(5, 5, 1'b0, 1'b0);
        scan(4, 10);
        checkVal("tp5_negX", int'(inSprite), 0);
        scan(10, 4);
        checkVal("tp5_negY", int'(inSprite), 0);

        // Reset mid-walk at bank 2, colliding with a frameStart
        doFrame(100, 100, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) doFrame(100, 100, 1'b1, 1'b0);
        checkVal("tp6_bank2", int'(frameSel), 2);
        DrawX = 10'd105; DrawY = 10'd105;
        doReset(1'b1);
        doFrame(100, 100, 1'b1, 1'b0);
        doFrame(100, 100, 1'b1, 1'b0);
        checkVal("tp6_fresh", int'(frameSel), 0);

        // Randomized frames with scans clustered around the sprite
        for (int f = 0; f < 120; f++) begin
            px = $urandom_range(0, 639);
            py = $urandom_range(0, 479);
            doFrame(px, py, ($urandom % 5) != 0, $urandom % 2);
            PosX = 10'($urandom_range(0, 639));
            PosY = 10'($urandom_range(0, 479));
            for (int s = 0; s < 8; s++) begin
                x = px + $urandom_range(0, SW + 5) - 3;
                y = py + $urandom_range(0, SH + 5) - 3;
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                scan(x, y);
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
